cache_tag_array_nway: RTL
=========================

Name: cache_tag_array_nway

Overview:
- N-way set-associative tag store: per-way tag, valid and dirty bits, plus a per-set round-robin victim pointer.
- Performs a registered lookup with hit/way/dirty detection and victim selection.
- Clears all valid/dirty state with a sequential sweep FSM, both on reset and on command.
- Sits between the cache controller FSM and the data array; replaces the single-way combinational-read tag memory in the next cache generation.

Parameters:
- WAYS, 4, associativity; power of two, ≥2.
- SETS, 256, number of sets; power of two.
- TAG_W, 18, tag width in bits.
- IDX_W, $clog2(SETS), set index width (derived; do not override).
- WAY_W, $clog2(WAYS), way index width (derived).

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when req_valid&req_ready.
- req_index  in  IDX_W  lookup set.
- req_tag  in  TAG_W  lookup tag.
- rsp_valid  out  1  lookup result valid (one-cycle pulse).
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  WAY_W  hit way; on miss, the victim way.
- rsp_dirty  out  1  dirty bit of rsp_way.
- rsp_victim_tag  out  TAG_W  stored tag of rsp_way (writeback address).
- wr_en  in  1  tag/state write.
- wr_index  in  IDX_W  write set.
- wr_way  in  WAY_W  write way.
- wr_tag  in  TAG_W  tag to store.
- wr_valid  in  1  valid bit to store.
- wr_dirty  in  1  dirty bit to store.
- inv_start  in  1  start a flash invalidate (pulse).
- inv_busy  out  1  sweep in progress.
- inv_done  out  1  one-cycle pulse on the last sweep cycle.

Behaviour:
- FSM states: SWEEP, IDLE. rst forces SWEEP with sweep counter=0, regardless of current state; reset mid-sweep restarts at set 0.
- SWEEP: each cycle clears valid and dirty for all ways of set[counter] and sets rr_ptr[counter]=0; counter+1. At counter==SETS-1: inv_done=1 that cycle, next state IDLE. Tags are not cleared.
- IDLE: inv_start=1 moves to SWEEP with counter=0 next cycle. inv_start during SWEEP is ignored.
- req_ready = (state==IDLE) && !inv_start. wr_en is ignored while state==SWEEP.
- Reset values: rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_dirty=0, rsp_victim_tag=0, inv_done=0, inv_busy=1, req_ready=0.
- After rst deasserts, req_ready is 0 for exactly SETS cycles. It rises the cycle after inv_done.
- Lookup latency: 1 cycle.
  - Accepted at edge N; rsp_* valid during cycle N+1.
  - rsp_valid=0 otherwise; rsp_* fields hold their last value.
  - Back-to-back lookups are supported, one per cycle.
- Hit: a way is valid and its tag == req_tag. If multiple ways match, the lowest-numbered way is reported; the controller never writes duplicates.
- Miss victim: the lowest-numbered invalid way, else rr_ptr[req_index]. rsp_dirty and rsp_victim_tag refer to that way.
- Write: on wr_en in IDLE, the selected way takes wr_tag/wr_valid/wr_dirty at the edge. If wr_valid=1, rr_ptr[wr_index] = (wr_way+1) mod WAYS, wrapping WAYS-1→0.
- Same-cycle lookup and write to the same set: the lookup sees pre-write contents (read-old); the write takes effect for lookups accepted on the next cycle.
- wr_en and inv_start in the same IDLE cycle: the write is performed, then the sweep starts.

Test Plan:
- Reset, then hold idle (WAYS=4, SETS=256) -> inv_busy=1 and req_ready=0 for 256 cycles; inv_done pulses once on cycle 256; req_ready=1 on cycle 257; all rsp_* = 0.
- Write set 5 way 2 tag 0x1ABCD valid=1 dirty=0, then lookup set 5 tag 0x1ABCD -> next cycle rsp_valid=1, hit=1, way=2, dirty=0.
- Set 9: fill ways 0-3 (tags 0x10-0x13, way 1 dirty) in order, then lookup tag 0x99 -> hit=0, way=0 (rr_ptr wrapped 3→0), victim_tag=0x10. Rewrite way 0, then lookup a miss -> way=1, dirty=1, victim_tag=0x11.
- Same cycle: lookup set 3 tag 0x7 while writing set 3 way 0 tag 0x7 valid=1 -> first rsp hit=0; an identical lookup next cycle -> hit=1, way=0.
- Populate sets 0 and 255, pulse inv_start -> req_ready=0 the same cycle, 256 sweep cycles, inv_done once; subsequent lookups miss with victim way=0, dirty=0. A write issued mid-sweep is dropped.
- Assert rst at sweep count 100 -> sweep restarts at 0; inv_done occurs 256 cycles after rst deasserts.

Source files
------------

// File: rtl/cache_tag_array_nway_if.sv
// cache_tag_array_nway_if: lookup, write and invalidate signals between cache controller and tag array
interface cache_tag_array_nway_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 18
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_dirty;
  logic [TAG_W-1:0] rsp_victim_tag;
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [WAY_W-1:0] wr_way;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_valid;
  logic             wr_dirty;
  logic             inv_start;
  logic             inv_busy;
  logic             inv_done;
  modport master (
    output req_valid, req_index, req_tag, wr_en, wr_index, wr_way, wr_tag, wr_valid, wr_dirty, inv_start,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim_tag, inv_busy, inv_done
  );
  modport slave (
    input  req_valid, req_index, req_tag, wr_en, wr_index, wr_way, wr_tag, wr_valid, wr_dirty, inv_start,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim_tag, inv_busy, inv_done
  );
endinterface

// File: rtl/cache_tag_array_nway.sv
// cache_tag_array_nway: n-way tag store with registered lookup, round-robin victim and sweep invalidate
module cache_tag_array_nway #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 18
) (
  input logic clk,
  input logic rst,
  cache_tag_array_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  typedef enum logic {SWEEP, IDLE} state_t;
  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [TAG_W-1:0] tags  [SETS][WAYS];
  logic [WAYS-1:0]  valid [SETS];
  logic [WAYS-1:0]  dirty [SETS];
  logic [WAY_W-1:0] rr    [SETS];
  logic             hit, any_free, acc, done;
  logic [WAY_W-1:0] hit_way, free_way, sel_way;
  assign done          = state == SWEEP && cnt == IDX_W'(SETS - 1);
  assign acc           = bus.req_valid && bus.req_ready;
  assign bus.req_ready = state == IDLE && !bus.inv_start;
  assign bus.inv_busy  = state == SWEEP;
  assign bus.inv_done  = done;
  // tag compare and victim choice; descending scan leaves the lowest-numbered way selected
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    any_free = 1'b0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[bus.req_index][i] && tags[bus.req_index][i] == bus.req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid[bus.req_index][i]) begin
        any_free = 1'b1;
        free_way = WAY_W'(i);
      end
    end
    sel_way = hit ? hit_way : any_free ? free_way : rr[bus.req_index];
  end
  // sweep/idle control; reset always restarts the sweep from set 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SWEEP;
      cnt   <= '0;
    end else if (state == SWEEP) begin
      cnt <= cnt + IDX_W'(1);
      if (done) state <= IDLE;
    end else if (bus.inv_start) begin
      state <= SWEEP;
      cnt   <= '0;
    end
  end
  // state storage: sweep clears one set per cycle, writes only land while idle; tags survive a sweep
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == SWEEP) begin
        valid[cnt] <= '0;
        dirty[cnt] <= '0;
        rr[cnt]    <= '0;
      end else if (bus.wr_en) begin
        tags[bus.wr_index][bus.wr_way]  <= bus.wr_tag;
        valid[bus.wr_index][bus.wr_way] <= bus.wr_valid;
        dirty[bus.wr_index][bus.wr_way] <= bus.wr_dirty;
        if (bus.wr_valid) rr[bus.wr_index] <= bus.wr_way + WAY_W'(1);
      end
    end
  end
  // registered lookup result; fields hold between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid      <= 1'b0;
      bus.rsp_hit        <= 1'b0;
      bus.rsp_way        <= '0;
      bus.rsp_dirty      <= 1'b0;
      bus.rsp_victim_tag <= '0;
    end else begin
      bus.rsp_valid <= acc;
      if (acc) begin
        bus.rsp_hit        <= hit;
        bus.rsp_way        <= sel_way;
        bus.rsp_dirty      <= dirty[bus.req_index][sel_way];
        bus.rsp_victim_tag <= tags[bus.req_index][sel_way];
      end
    end
  end
endmodule
